// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock.
// A full-subtractor cell in borrow form is reused across WIDTH cycles.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [WIDTH-1:0]  sa;
    logic [WIDTH-1:0]  sb;
    logic [WIDTH-1:0]  sd;
    logic              br;
    logic [CNT_W-1:0]  cnt;
    logic              a_msb;
    logic              b_msb;

    logic              x;
    logic              y;
    logic              d;
    logic              bw;
    logic              last;
    logic              accept;
    logic [WIDTH-1:0]  sd_nxt;

    // One-bit borrow cell plus shift-in of the new difference bit at the MSB.
    always_comb begin
        x      = sa[0];
        y      = sb[0];
        d      = x ^ y ^ br;
        bw     = (~x & y) | (~x & br) | (y & br);
        sd_nxt = (sd >> 1) | (WIDTH'(d) << (WIDTH - 1));
        last   = (cnt == CNT_W'(WIDTH - 1));
        // start is only honoured when not busy, so operands cannot be corrupted mid-run
        accept = (state != RUN) && bus.start;
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; DONE accepts a new start directly for back-to-back use.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state flops (no input paths).
    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
    end

    // Operand capture and per-bit shifting of the working registers.
    // NOTE: every register here is cleared by reset, including the shift registers,
    // so a reset mid-operation leaves no stale partial result behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa    <= '0;
            sb    <= '0;
            sd    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (accept) begin
            sa    <= bus.a;
            sb    <= bus.b;
            sd    <= '0;
            br    <= bus.bin;
            cnt   <= '0;
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
        end else if (state == RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            sd    <= sd_nxt;
            br    <= bw;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Result registers load only on the edge that processes the last bit and
    // otherwise hold the previous result through the next operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.diff <= '0;
            bus.bout <= 1'b0;
            bus.ovf  <= 1'b0;
        end else if ((state == RUN) && last) begin
            bus.diff <= sd_nxt;
            bus.bout <= bw;
            // overflow only possible when operand signs differ and the result sign
            // departs from the minuend's
            bus.ovf  <= (a_msb ^ b_msb) & (sd_nxt[WIDTH-1] ^ a_msb);
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of serial_subtractor at WIDTH = 1, 8 and 13.
module tb_serial_subtractor;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(1))  bus1  ();
    serial_subtractor_if #(.WIDTH(8))  bus8  ();
    serial_subtractor_if #(.WIDTH(13)) bus13 ();

    serial_subtractor #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
    serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_subtractor #(.WIDTH(13)) dut13 (.clk(clk), .rst_n(rst_n), .bus(bus13));

    int checks = 0;
    int passed = 0;

    // Last completed result of the 8-bit DUT, for the hold-while-busy check.
    logic [7:0] prev_diff8 = '0;
    logic       prev_bout8 = 1'b0;
    logic       prev_ovf8  = 1'b0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: a - b - bin on a (w+1)-bit value.
    function automatic void ref_sub(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic bin, output logic [31:0] diff,
                                    output logic bout, output logic ovf);
        logic [32:0] full;
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        full = {1'b0, a & mask} - {1'b0, b & mask} - 33'(bin);
        diff = full[31:0] & mask;
        bout = full[w];
        ovf  = (a[w-1] != b[w-1]) && (diff[w-1] != a[w-1]);
    endfunction

    function automatic logic [7:0] op_a(input int c);
        return 8'(c * 37 + 11);
    endfunction

    function automatic logic [7:0] op_b(input int c);
        return 8'(c * 91 + 5);
    endfunction

    // One 8-bit operation: latency, busy window, hold of old result, new result.
    task automatic do_op8(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic bin, input logic [7:0] ed, input logic eb,
                          input logic eo);
        int cyc;
        bit stable;
        bit busy_ok;
        bus8.a     = a;
        bus8.b     = b;
        bus8.bin   = bin;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        bus8.a     = ~a;
        bus8.b     = a ^ b;
        bus8.bin   = ~bin;
        cyc     = 0;
        stable  = 1'b1;
        busy_ok = 1'b1;
        while (bus8.done !== 1'b1 && cyc < 20) begin
            if (bus8.busy !== 1'b1) busy_ok = 1'b0;
            if (bus8.diff !== prev_diff8 || bus8.bout !== prev_bout8 || bus8.ovf !== prev_ovf8)
                stable = 1'b0;
            bus8.start = (cyc == 3);
            tick();
            cyc++;
        end
        bus8.start = 1'b0;
        checks++;
        if (cyc != 8 || !busy_ok)
            $display("FAIL %s latency: done after %0d edges busy_ok=%0b, expected 8 edges with busy=1",
                     name, cyc, busy_ok);
        else passed++;
        checks++;
        if (bus8.busy !== 1'b0)
            $display("FAIL %s busy_at_done: got %b expected 0", name, bus8.busy);
        else passed++;
        checks++;
        if (bus8.diff !== ed)
            $display("FAIL %s diff: got %h expected %h", name, bus8.diff, ed);
        else passed++;
        checks++;
        if (bus8.bout !== eb || bus8.ovf !== eo)
            $display("FAIL %s bout/ovf: got %b/%b expected %b/%b", name, bus8.bout, bus8.ovf, eb, eo);
        else passed++;
        checks++;
        if (!stable)
            $display("FAIL %s hold: outputs changed while busy, expected %h/%b/%b",
                     name, prev_diff8, prev_bout8, prev_ovf8);
        else passed++;
        tick();
        checks++;
        if (bus8.done !== 1'b0)
            $display("FAIL %s done_pulse: got %b one cycle later, expected 0", name, bus8.done);
        else passed++;
        prev_diff8 = ed;
        prev_bout8 = eb;
        prev_ovf8  = eo;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({bus8.busy, bus8.done, bus8.diff, bus8.bout, bus8.ovf} !== 12'h000)
            $display("FAIL reset_w8: got busy=%b done=%b diff=%h bout=%b ovf=%b, expected all 0",
                     bus8.busy, bus8.done, bus8.diff, bus8.bout, bus8.ovf);
        else passed++;
        checks++;
        if ({bus1.busy, bus1.done, bus1.diff, bus13.busy, bus13.done, bus13.diff} !== 18'h0)
            $display("FAIL reset_w1_w13: got %b/%b/%h and %b/%b/%h, expected all 0",
                     bus1.busy, bus1.done, bus1.diff, bus13.busy, bus13.done, bus13.diff);
        else passed++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        do_op8("basic_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    endtask

    task automatic test_borrow_overflow;
        do_op8("borrow_00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        do_op8("ovf_80_01",    8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    endtask

    task automatic test_borrow_in;
        do_op8("bin_10_0f",    8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
        do_op8("ovf_7f_ff",    8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back;
        logic [31:0] ed;
        logic        eb;
        logic        eo;
        int          n;
        for (int c = 0; c < 40; c++) begin
            bus8.a     = op_a(c);
            bus8.b     = op_b(c);
            bus8.bin   = c[0];
            bus8.start = 1'b1;
            tick();
            checks++;
            if (c % 9 == 8) begin
                ref_sub(8, 32'(op_a(c - 8)), 32'(op_b(c - 8)), (c - 8) % 2 == 1, ed, eb, eo);
                if (bus8.done !== 1'b1 || bus8.diff !== ed[7:0] || bus8.bout !== eb || bus8.ovf !== eo)
                    $display("FAIL b2b_result cycle %0d: got done=%b diff=%h bout=%b ovf=%b, expected 1/%h/%b/%b",
                             c, bus8.done, bus8.diff, bus8.bout, bus8.ovf, ed[7:0], eb, eo);
                else passed++;
            end else begin
                if (bus8.done !== 1'b0)
                    $display("FAIL b2b_spacing cycle %0d: got done=%b expected 0", c, bus8.done);
                else passed++;
            end
        end
        bus8.start = 1'b0;
        n = 0;
        while (bus8.done !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        ref_sub(8, 32'(op_a(36)), 32'(op_b(36)), 1'b0, ed, eb, eo);
        checks++;
        if (n != 5 || bus8.diff !== ed[7:0] || bus8.bout !== eb || bus8.ovf !== eo)
            $display("FAIL b2b_drain: got %0d edges diff=%h bout=%b ovf=%b, expected 5 edges %h/%b/%b",
                     n, bus8.diff, bus8.bout, bus8.ovf, ed[7:0], eb, eo);
        else passed++;
        tick();
        prev_diff8 = ed[7:0];
        prev_bout8 = eb;
        prev_ovf8  = eo;
    endtask

    task automatic test_reset_mid_run;
        bit saw_done;
        do_op8("pre_reset", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
        bus8.a     = 8'hC3;
        bus8.b     = 8'h21;
        bus8.bin   = 1'b1;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus8.busy, bus8.done, bus8.diff, bus8.bout, bus8.ovf} !== 12'h000)
            $display("FAIL reset_mid_run: got busy=%b done=%b diff=%h bout=%b ovf=%b, expected all 0",
                     bus8.busy, bus8.done, bus8.diff, bus8.bout, bus8.ovf);
        else passed++;
        #1;
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done)
            $display("FAIL reset_abort: got done/busy activity after reset, expected none");
        else passed++;
        prev_diff8 = '0;
        prev_bout8 = 1'b0;
        prev_ovf8  = 1'b0;
        do_op8("post_reset", 8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0);
    endtask

    task automatic test_random_w8;
        logic [31:0] ed;
        logic        eb;
        logic        eo;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic        rbin;
        for (int n = 0; n < 1000; n++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            ref_sub(8, 32'(ra), 32'(rb), rbin, ed, eb, eo);
            do_op8("rand_w8", ra, rb, rbin, ed[7:0], eb, eo);
        end
    endtask

    task automatic test_random_w1;
        logic [31:0] ed;
        logic        eb;
        logic        eo;
        logic [0:0]  pd = '0;
        logic        pb = 1'b0;
        logic        po = 1'b0;
        logic [0:0]  ra;
        logic [0:0]  rb;
        logic        rbin;
        int          cyc;
        bit          stable;
        for (int n = 0; n < 1000; n++) begin
            ra   = 1'($urandom);
            rb   = 1'($urandom);
            rbin = 1'($urandom);
            ref_sub(1, 32'(ra), 32'(rb), rbin, ed, eb, eo);
            bus1.a = ra; bus1.b = rb; bus1.bin = rbin; bus1.start = 1'b1;
            tick();
            bus1.start = 1'b0; bus1.a = ~ra; bus1.b = ~rb; bus1.bin = ~rbin;
            cyc = 0;
            stable = 1'b1;
            while (bus1.done !== 1'b1 && cyc < 10) begin
                if (bus1.busy !== 1'b1 || bus1.diff !== pd || bus1.bout !== pb || bus1.ovf !== po)
                    stable = 1'b0;
                tick();
                cyc++;
            end
            checks++;
            if (cyc != 1 || !stable)
                $display("FAIL rand_w1 timing op %0d: done after %0d edges stable=%0b, expected 1 edge held",
                         n, cyc, stable);
            else passed++;
            checks++;
            if (bus1.diff !== ed[0:0] || bus1.bout !== eb || bus1.ovf !== eo)
                $display("FAIL rand_w1 result op %0d: got %b/%b/%b expected %b/%b/%b",
                         n, bus1.diff, bus1.bout, bus1.ovf, ed[0], eb, eo);
            else passed++;
            tick();
            pd = ed[0:0]; pb = eb; po = eo;
        end
    endtask

    task automatic test_random_w13;
        logic [31:0] ed;
        logic        eb;
        logic        eo;
        logic [12:0] pd = '0;
        logic        pb = 1'b0;
        logic        po = 1'b0;
        logic [12:0] ra;
        logic [12:0] rb;
        logic        rbin;
        int          cyc;
        bit          stable;
        for (int n = 0; n < 1000; n++) begin
            ra   = 13'($urandom);
            rb   = 13'($urandom);
            rbin = 1'($urandom);
            ref_sub(13, 32'(ra), 32'(rb), rbin, ed, eb, eo);
            bus13.a = ra; bus13.b = rb; bus13.bin = rbin; bus13.start = 1'b1;
            tick();
            bus13.start = 1'b0; bus13.a = ~ra; bus13.b = ra ^ rb; bus13.bin = ~rbin;
            cyc = 0;
            stable = 1'b1;
            while (bus13.done !== 1'b1 && cyc < 30) begin
                if (bus13.busy !== 1'b1 || bus13.diff !== pd || bus13.bout !== pb || bus13.ovf !== po)
                    stable = 1'b0;
                bus13.start = (cyc == 6);
                tick();
                cyc++;
            end
            bus13.start = 1'b0;
            checks++;
            if (cyc != 13 || !stable)
                $display("FAIL rand_w13 timing op %0d: done after %0d edges stable=%0b, expected 13 edges held",
                         n, cyc, stable);
            else passed++;
            checks++;
            if (bus13.diff !== ed[12:0] || bus13.bout !== eb || bus13.ovf !== eo)
                $display("FAIL rand_w13 result op %0d: got %h/%b/%b expected %h/%b/%b",
                         n, bus13.diff, bus13.bout, bus13.ovf, ed[12:0], eb, eo);
            else passed++;
            tick();
            pd = ed[12:0]; pb = eb; po = eo;
        end
    endtask

    initial begin
        bus1.start  = 1'b0; bus1.a  = '0; bus1.b  = '0; bus1.bin  = 1'b0;
        bus8.start  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.bin  = 1'b0;
        bus13.start = 1'b0; bus13.a = '0; bus13.b = '0; bus13.bin = 1'b0;
        test_reset();
        test_basic();
        test_borrow_overflow();
        test_borrow_in();
        test_back_to_back();
        test_reset_mid_run();
        test_random_w8();
        test_random_w1();
        test_random_w13();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing diff = a − b − bin, LSB first, one bit per clock. It reuses the one-bit sum/carry structure of the team's adder, in borrow form: d = x^y^br and borrow = (~x&y)|(~x&br)|(y&br). It is the area-cheap subtract path for datapaths that can spend WIDTH cycles per operation, and it uses a start/busy/done handshake.

## Interface
- WIDTH, 8, operand and result width in bits; legal range WIDTH ≥ 1.

- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on the rising edge only while busy=0.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- bin  input  1  borrow-in; captured on the accepting edge.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse; diff, bout and ovf are valid from this cycle onward.
- diff  output  WIDTH  result a − b − bin, modulo 2^WIDTH.
- bout  output  1  final borrow-out (1 means unsigned a < b + bin).
- ovf  output  1  signed two's-complement overflow of the subtraction.

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - busy=0, done=0.
  - start=1 → capture a, b and bin into internal shift registers sa, sb and borrow flop br.
  - Clear the bit counter cnt (width clog2(WIDTH+1)) and go to RUN.
- RUN
  - busy=1.
  - Each cycle, combine x=sa[0], y=sb[0] and br.
  - The difference bit d is shifted into the MSB of internal accumulator sd.
  - sa and sb shift right; br takes the new borrow; cnt increments.
  - On the edge where cnt reaches WIDTH−1 (the last bit processed):
    - diff ← completed sd;
    - bout ← final borrow;
    - ovf ← (a_msb ≠ b_msb) & (diff_msb ≠ a_msb), using the captured operand MSBs held in dedicated flops;
    - go to DONE.
- DONE
  - busy=0, done=1 for exactly one cycle, then IDLE.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back), going straight to RUN.
- start while busy=1 is ignored; it is neither queued nor allowed to corrupt operands.
- Output registers diff, bout and ovf change only on the completion edge.
  - They hold the previous result throughout the next operation until its completion.
- Inputs a, b and bin may change freely after the accepting edge.

## Timing
- Reset (rst_n=0, asynchronous, any state): state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0.
  - Internal sa, sb, sd, br and cnt are also cleared.
- Reset mid-RUN aborts the operation: no done pulse, and the previous result is lost (outputs become 0).
- Release of rst_n is synchronous to clk; the first start is sampled on the first rising edge with rst_n=1.
- Let the accepting edge be E0.
  - busy=1 from after E0 through edge E0+WIDTH.
  - After E0+WIDTH: busy=0, done=1, and results are valid.
  - After E0+WIDTH+1: done=0, unless restarted.
- Latency from start to done: WIDTH+1 edges, counting the accepting edge as the first.
- Throughput: one operation per WIDTH+1 cycles with back-to-back start.
- WIDTH=1: RUN lasts one cycle and the completion rule still applies.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, bin=0, start for 1 cycle → busy high for 8 cycles, then done pulse with diff=0x1E, bout=0, ovf=0.
- a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1, ovf=0. Then a=0x80, b=0x01 → diff=0x7F, bout=0, ovf=1.
- a=0x10, b=0x0F, bin=1 → diff=0x00, bout=0. Then a=0x7F, b=0xFF, bin=0 → diff=0x80, bout=1, ovf=1.
- Hold start=1 continuously, changing a and b every cycle → each done pulse is spaced exactly 9 cycles apart.
  - Each result matches the operands present on its accepting edge.
  - The mid-RUN start pulses and operand changes have no effect.
- Reset (rst_n low) asynchronously between edges E0+4 and E0+5 of a run whose prior result was nonzero → all outputs read 0 immediately and no done occurs.
  - A subsequent start yields a correct result.
- Randomized check: 1000 operations each at WIDTH=1, 8 and 13, compared against a − b − bin on a (WIDTH+1)-bit reference.
  - Checks diff, bout and ovf.
  - Confirms diff/bout/ovf stay stable while busy=1.
